freq_meter_core: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 20 ++
 rtl/freq_sync_edge.sv | 27 ++
 rtl/freq_meter_core.sv | 109 ++++++++++
 tb/tb_freq_meter_core.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the reciprocal frequency meter.
package freq_meter_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE,
        DONE
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/freq_sync_edge.sv
// Synchroniser for the asynchronous signal under test, followed by a
// registered rising-edge detector (edge_p lags sig_in by SYNC_STAGES+1 cycles).
module freq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_p <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_p <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/freq_meter_core.sv
// Equal-precision frequency meter: gate opens and closes on signal edges,
// counting reference cycles and signal periods for the fmeasure PIO inputs.
module freq_meter_core
    import freq_meter_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int GATE_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] fmeasure_clk_export,
    output logic [CNT_W-1:0] fmeasure_sqr_export,
    output logic             meas_valid,
    output logic             meas_busy,
    output logic             meas_timeout
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_q, state_d;
    logic               edge_p;
    logic [CNT_W-1:0]   ref_cnt, sig_cnt, sig_inc;
    logic [GATE_W-1:0]  gate_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               to_hit, close_gate;

    freq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk    (clk_clk),
        .rst    (reset_reset),
        .sig_in (sig_in),
        .edge_p (edge_p)
    );

    // Separate unsaturated gate counter so the gate still closes when
    // ref_cnt has pinned at its maximum.
    assign close_gate = edge_p && (gate_cnt == GATE_W'(GATE_CYCLES));
    assign to_hit     = !edge_p && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign sig_inc    = CNT_W'(sat_inc(64'(sig_cnt), CNT_W));
    assign meas_busy  = (state_q == WAIT_EDGE) || (state_q == MEASURE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (meas_en) state_d = WAIT_EDGE;
            WAIT_EDGE: begin
                if (edge_p)      state_d = MEASURE;
                else if (to_hit) state_d = DONE;
            end
            MEASURE:   if (close_gate || to_hit) state_d = DONE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q             <= IDLE;
            ref_cnt             <= '0;
            sig_cnt             <= '0;
            gate_cnt            <= '0;
            to_cnt              <= '0;
            fmeasure_clk_export <= '0;
            fmeasure_sqr_export <= '0;
            meas_valid          <= 1'b0;
            meas_timeout        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: to_cnt <= '0;
                WAIT_EDGE: begin
                    // The opening-edge cycle counts as 0, so the next cycle holds 1.
                    if (edge_p) begin
                        ref_cnt  <= CNT_W'(1);
                        gate_cnt <= GATE_W'(1);
                        sig_cnt  <= '0;
                        to_cnt   <= TO_W'(1);
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                MEASURE: begin
                    ref_cnt <= CNT_W'(sat_inc(64'(ref_cnt), CNT_W));
                    if (gate_cnt != GATE_W'(GATE_CYCLES))
                        gate_cnt <= gate_cnt + GATE_W'(1);
                    if (edge_p) begin
                        sig_cnt <= sig_inc;
                        to_cnt  <= TO_W'(1);
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase

            // Results are registered on entry to DONE so they line up with meas_valid.
            meas_valid <= (state_d == DONE);
            if (state_d == DONE) begin
                fmeasure_clk_export <= to_hit ? '0 : ref_cnt;
                fmeasure_sqr_export <= to_hit ? '0 : sig_inc;
                meas_timeout        <= to_hit;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_core.sv
// Randomised self-checking bench for freq_meter_core against an arithmetic
// model of the gate: the gate closes on the first edge at or beyond GATE_CYCLES.
module tb_freq_meter_core;

    localparam int GATE_A = 100;
    localparam int GATE_B = 300;
    localparam int TO_CYC = 50;

    logic        clk = 1'b0;
    logic        sig_in = 1'b0;
    int          period = 0;

    logic        rst_a, en_a, valid_a, busy_a, to_a;
    logic [31:0] clk_a, sqr_a;
    logic        rst_b, en_b, valid_b, busy_b, to_b;
    logic [7:0]  clk_b, sqr_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    freq_meter_core #(.CNT_W(32), .GATE_CYCLES(GATE_A), .TIMEOUT_CYCLES(TO_CYC), .SYNC_STAGES(2)) dut_a (
        .clk_clk(clk), .reset_reset(rst_a), .sig_in(sig_in), .meas_en(en_a),
        .fmeasure_clk_export(clk_a), .fmeasure_sqr_export(sqr_a),
        .meas_valid(valid_a), .meas_busy(busy_a), .meas_timeout(to_a)
    );

    freq_meter_core #(.CNT_W(8), .GATE_CYCLES(GATE_B), .TIMEOUT_CYCLES(TO_CYC), .SYNC_STAGES(2)) dut_b (
        .clk_clk(clk), .reset_reset(rst_b), .sig_in(sig_in), .meas_en(en_b),
        .fmeasure_clk_export(clk_b), .fmeasure_sqr_export(sqr_b),
        .meas_valid(valid_b), .meas_busy(busy_b), .meas_timeout(to_b)
    );

    // Square wave with an exact period in clk cycles; period < 2 holds it low.
    initial begin : sig_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (period < 2) begin
                sig_in = 1'b0;
                ph = 0;
            end else begin
                ph = (ph + 1 >= period) ? 0 : ph + 1;
                sig_in = (ph < period / 2);
            end
        end
    end

    // Reference model: k periods fit once k*p >= gate; counts saturate at width w.
    function automatic void model(input int g, input int p, input int w,
                                  output longint r, output longint s);
        longint k, cap;
        k   = (g + p - 1) / p;
        cap = (longint'(1) << w) - 1;
        r   = (k * p > cap) ? cap : k * p;
        s   = (k > cap) ? cap : k;
    endfunction

    task automatic wait_valid_a(input int max_cyc, output bit ok, output int cyc);
        ok = 0;
        cyc = 0;
        while (!ok && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (valid_a === 1'b1) ok = 1;
        end
    endtask

    task automatic wait_busy_a(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (busy_a === 1'b1) ok = 1;
        end
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy_a === 1'b0 && valid_a === 1'b0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; en_a = 0; en_b = 0;
        repeat (4) @(negedge clk);
        n_chk++; if (clk_a !== 32'd0 || sqr_a !== 32'd0) begin n_fail++;
            $display("FAIL reset_exports_a: got %0d/%0d want 0/0", clk_a, sqr_a); end
        n_chk++; if ({valid_a, busy_a, to_a} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags_a: got v/b/t=%b want 000", {valid_a, busy_a, to_a}); end
        n_chk++; if (clk_b !== 8'd0 || sqr_b !== 8'd0 || {valid_b, busy_b, to_b} !== 3'b000) begin n_fail++;
            $display("FAIL reset_b: got %0d/%0d flags %b want 0/0 000", clk_b, sqr_b, {valid_b, busy_b, to_b}); end
        rst_a = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok; int cyc; longint er, es;
        period = 10;
        repeat (20) @(negedge clk);
        model(GATE_A, 10, 32, er, es);
        en_a = 1;
        wait_valid_a(400, ok, cyc);
        en_a = 0;
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_valid: got no pulse want pulse"); end
        n_chk++; if (clk_a !== 32'(er) || sqr_a !== 32'(es)) begin n_fail++;
            $display("FAIL basic_result: got %0d/%0d want %0d/%0d", clk_a, sqr_a, er, es); end
        n_chk++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to_a); end
        @(negedge clk);
        n_chk++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b want 0", valid_a); end
        wait_idle_a();
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; longint er, es;
        period = 7;
        repeat (20) @(negedge clk);
        model(GATE_A, 7, 32, er, es);
        en_a = 1;
        wait_valid_a(400, ok, cyc);
        n_chk++; if (!ok || clk_a !== 32'(er) || sqr_a !== 32'(es)) begin n_fail++;
            $display("FAIL b2b_first: got %0d/%0d ok=%0d want %0d/%0d", clk_a, sqr_a, ok, er, es); end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (busy_a !== 1'b1 && cyc < 20);
        n_chk++; if (cyc != 2) begin n_fail++; $display("FAIL b2b_restart_gap: got %0d want 2", cyc); end
        wait_valid_a(400, ok, cyc);
        en_a = 0;
        n_chk++; if (!ok || clk_a !== 32'(er) || sqr_a !== 32'(es)) begin n_fail++;
            $display("FAIL b2b_second: got %0d/%0d ok=%0d want %0d/%0d", clk_a, sqr_a, ok, er, es); end
        wait_idle_a();
    endtask

    task automatic test_timeout();
        bit ok; int cyc; longint er, es;
        period = 0;
        repeat (10) @(negedge clk);
        en_a = 1;
        wait_busy_a(10, ok);
        wait_valid_a(200, ok, cyc);
        en_a = 0;
        n_chk++; if (!ok || cyc != TO_CYC) begin n_fail++;
            $display("FAIL timeout_latency: got %0d cycles ok=%0d want %0d", cyc, ok, TO_CYC); end
        n_chk++; if (clk_a !== 32'd0 || sqr_a !== 32'd0 || to_a !== 1'b1) begin n_fail++;
            $display("FAIL timeout_result: got %0d/%0d to=%b want 0/0 to=1", clk_a, sqr_a, to_a); end
        wait_idle_a();
        period = 10;
        repeat (30) @(negedge clk);
        model(GATE_A, 10, 32, er, es);
        en_a = 1;
        wait_valid_a(400, ok, cyc);
        en_a = 0;
        n_chk++; if (!ok || to_a !== 1'b0 || clk_a !== 32'(er) || sqr_a !== 32'(es)) begin n_fail++;
            $display("FAIL timeout_recover: got %0d/%0d to=%b want %0d/%0d to=0", clk_a, sqr_a, to_a, er, es); end
        wait_idle_a();
    endtask

    task automatic test_reset_mid();
        bit ok, seen; int cyc; longint er, es;
        period = 10;
        model(GATE_A, 10, 32, er, es);
        en_a = 1;
        wait_busy_a(10, ok);
        repeat (30) @(negedge clk);
        rst_a = 1;
        @(negedge clk);
        rst_a = 0;
        n_chk++; if (clk_a !== 32'd0 || sqr_a !== 32'd0 || busy_a !== 1'b0 || valid_a !== 1'b0) begin n_fail++;
            $display("FAIL reset_mid: got %0d/%0d busy=%b valid=%b want 0/0 busy=0 valid=0",
                     clk_a, sqr_a, busy_a, valid_a); end
        seen = 0;
        wait_valid_a(400, ok, cyc);
        en_a = 0;
        n_chk++; if (!ok || clk_a !== 32'(er) || sqr_a !== 32'(es)) begin n_fail++;
            $display("FAIL reset_mid_after: got %0d/%0d ok=%0d want %0d/%0d", clk_a, sqr_a, ok, er, es); end
        wait_idle_a();
    endtask

    task automatic test_en_drop();
        bit ok; int cyc, bad; longint er, es;
        period = 10;
        model(GATE_A, 10, 32, er, es);
        en_a = 1;
        wait_busy_a(10, ok);
        repeat (30) @(negedge clk);
        en_a = 0;
        wait_valid_a(400, ok, cyc);
        n_chk++; if (!ok || clk_a !== 32'(er) || sqr_a !== 32'(es)) begin n_fail++;
            $display("FAIL en_drop_result: got %0d/%0d ok=%0d want %0d/%0d", clk_a, sqr_a, ok, er, es); end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || valid_a !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL en_drop_idle: got %0d busy cycles want 0", bad); end
    endtask

    task automatic test_random();
        bit ok; int cyc, p; longint er, es;
        repeat (6) begin
            p = int'($urandom_range(3, 40));
            period = p;
            repeat (2 * p + 5) @(negedge clk);
            model(GATE_A, p, 32, er, es);
            en_a = 1;
            wait_valid_a(600, ok, cyc);
            en_a = 0;
            n_chk++; if (!ok || clk_a !== 32'(er) || sqr_a !== 32'(es)) begin n_fail++;
                $display("FAIL random_p%0d: got %0d/%0d ok=%0d want %0d/%0d", p, clk_a, sqr_a, ok, er, es); end
            wait_idle_a();
        end
    endtask

    task automatic test_saturation();
        bit ok; longint er, es;
        period = 10;
        model(GATE_B, 10, 8, er, es);
        rst_b = 0;
        repeat (5) @(negedge clk);
        en_b = 1;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (valid_b === 1'b1) ok = 1;
        end
        en_b = 0;
        n_chk++; if (!ok || clk_b !== 8'(er) || sqr_b !== 8'(es) || to_b !== 1'b0) begin n_fail++;
            $display("FAIL saturation: got %0d/%0d to=%b ok=%0d want %0d/%0d to=0", clk_b, sqr_b, to_b, ok, er, es); end
    endtask

    initial begin
        rst_a = 1; rst_b = 1; en_a = 0; en_b = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_en_drop();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
